memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 147 ++++++++++++++
 tb/tb_memory_access.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// Memory-access pipeline stage: forwards ALU results, performs aligned loads/stores
// over a simple request/completion bus, and reports misaligned accesses.
module memory_access #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [1:0]      in_memop,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd,
  input  logic            in_regwrite,
  output logic            in_ready,
  input  logic            flush,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [1:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_wdata,
  input  logic            dresp_ok,
  input  logic [XLEN-1:0] dresp_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_regwrite,
  output logic            out_misalign,
  output logic            state_dbg
);

  // Handshake: an instruction is taken on any cycle where in_valid && in_ready.
  // A bus request holds dreq_valid and all dreq_* fields stable until the cycle
  // dresp_ok is sampled high; dresp_ok outside a request is ignored.
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] l_pc;
  logic [4:0]      l_rd;
  logic            l_regwrite, l_unsigned, l_store, killed;
  logic            is_mem, misalign, take;
  logic [7:0]      size_mask;
  logic [XLEN-1:0] shifted, load_val;

  assign is_mem     = (in_memop == 2'd1) || (in_memop == 2'd2);
  assign take       = (state == S_IDLE) && in_valid && !flush;
  assign in_ready   = (state == S_IDLE);
  assign dreq_valid = (state == S_WAIT);
  assign state_dbg  = state;

  always_comb begin
    misalign  = 1'b0;
    size_mask = 8'h01;
    case (in_size)
      2'd0: begin misalign = 1'b0;               size_mask = 8'h01; end
      2'd1: begin misalign = in_alu_out[0];      size_mask = 8'h03; end
      2'd2: begin misalign = |in_alu_out[1:0];   size_mask = 8'h0F; end
      default: begin misalign = |in_alu_out[2:0]; size_mask = 8'hFF; end
    endcase
  end

  // Returned doubleword is aligned; bring the addressed bytes down to bit 0 first.
  always_comb begin
    shifted  = dresp_rdata >> {dreq_addr[2:0], 3'b000};
    load_val = shifted;
    case (dreq_size)
      2'd0: load_val = {{(XLEN-8){~l_unsigned & shifted[7]}}, shifted[7:0]};
      2'd1: load_val = {{(XLEN-16){~l_unsigned & shifted[15]}}, shifted[15:0]};
      2'd2: load_val = {{(XLEN-32){~l_unsigned & shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (take && is_mem && !misalign) state_nx = S_WAIT;
      S_WAIT: if (dresp_ok) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      l_pc         <= '0;
      l_rd         <= '0;
      l_regwrite   <= 1'b0;
      l_unsigned   <= 1'b0;
      l_store      <= 1'b0;
      killed       <= 1'b0;
      dreq_addr    <= '0;
      dreq_size    <= '0;
      dreq_strobe  <= '0;
      dreq_wdata   <= '0;
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_result   <= '0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
      out_misalign <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take && (!is_mem || misalign)) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_rd       <= in_rd;
            out_result   <= in_alu_out;
            out_regwrite <= is_mem ? 1'b0 : in_regwrite;
            out_misalign <= is_mem;
          end else if (take) begin
            l_pc        <= in_pc;
            l_rd        <= in_rd;
            l_regwrite  <= in_regwrite;
            l_unsigned  <= in_unsigned;
            l_store     <= (in_memop == 2'd2);
            killed      <= 1'b0;
            dreq_addr   <= in_alu_out;
            dreq_size   <= in_size;
            dreq_strobe <= (in_memop == 2'd2) ? (size_mask << in_alu_out[2:0]) : 8'h00;
            dreq_wdata  <= (in_memop == 2'd2) ? (in_wdata << {in_alu_out[2:0], 3'b000}) : '0;
          end
        end
        S_WAIT: begin
          if (flush) killed <= 1'b1;
          // A flushed request still completes on the bus but never retires.
          if (dresp_ok && !killed && !flush) begin
            out_valid    <= 1'b1;
            out_pc       <= l_pc;
            out_rd       <= l_rd;
            out_result   <= l_store ? dreq_addr : load_val;
            out_regwrite <= l_store ? 1'b0 : l_regwrite;
            out_misalign <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access with a byte-arithmetic reference model and
// directed cases for the ALU, byte/half access, misalign, flush and reset paths.
module tb_memory_access;

  logic        clk, reset, in_valid, in_unsigned, in_regwrite, in_ready, flush;
  logic [63:0] in_pc, in_alu_out, in_wdata, dreq_addr, dreq_wdata, dresp_rdata;
  logic [1:0]  in_memop, in_size, dreq_size;
  logic [4:0]  in_rd, out_rd;
  logic        dreq_valid, dresp_ok, out_valid, out_regwrite, out_misalign, state_dbg;
  logic [7:0]  dreq_strobe;
  logic [63:0] out_pc, out_result;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  memory_access #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_alu_out(in_alu_out), .in_memop(in_memop), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_ready(in_ready), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata), .dresp_ok(dresp_ok),
    .dresp_rdata(dresp_rdata), .out_valid(out_valid), .out_pc(out_pc),
    .out_result(out_result), .out_rd(out_rd), .out_regwrite(out_regwrite),
    .out_misalign(out_misalign), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: plain byte arithmetic on the access rules
  function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [63:0] addr,
                                             input int size, input bit uns);
    int bits = 8 << size;
    logic [63:0] mask = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
    logic [63:0] v = (rdata >> (8 * (addr % 8))) & mask;
    if (!uns && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] model_strobe(input logic [63:0] addr, input int size);
    logic [15:0] s = ((16'd1 << (1 << size)) - 16'd1) << (addr % 8);
    return s[7:0];
  endfunction

  // driver tasks
  task automatic drive_in(input logic [1:0] memop, input logic [1:0] size, input logic [63:0] addr,
                          input logic [63:0] wd, input bit uns, input bit rw,
                          input logic [63:0] pc, input logic [4:0] rd);
    in_valid = 1'b1; in_memop = memop; in_size = size; in_alu_out = addr;
    in_wdata = wd; in_unsigned = uns; in_regwrite = rw; in_pc = pc; in_rd = rd;
  endtask

  task automatic run_txn(input logic [1:0] memop, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] wd, input bit uns, input bit rw,
                         input logic [63:0] rdata, input int delay, input bit kill);
    bit is_mem = (memop == 2'd1) || (memop == 2'd2);
    bit store  = (memop == 2'd2);
    bit mis    = is_mem && ((addr % (64'd1 << size)) != 0);
    logic [63:0] pc = {$urandom, $urandom};
    logic [4:0]  rd = 5'($urandom);
    int hi = 0;
    check("ready_before", 64'(in_ready), 64'd1);
    drive_in(memop, size, addr, wd, uns, rw, pc, rd);
    @(negedge clk);
    in_valid = 1'b0;
    if (!is_mem || mis) begin
      check("noreq_dreq", 64'(dreq_valid), 64'd0);
      check("fast_valid", 64'(out_valid), 64'd1);
      check("fast_misalign", 64'(out_misalign), 64'(mis));
      check("fast_regwrite", 64'(out_regwrite), mis ? 64'd0 : 64'(rw));
      check("fast_pc", out_pc, pc);
      check("fast_rd", 64'(out_rd), 64'(rd));
      if (!mis) begin
        exp_q.push_back(addr);
        check("alu_result", out_result, exp_q.pop_front());
      end
    end else begin
      if (!kill) exp_q.push_back(store ? addr : model_load(rdata, addr, int'(size), uns));
      for (int k = 0; k <= delay; k++) begin
        hi += int'(dreq_valid);
        check("wait_valid", 64'(dreq_valid), 64'd1);
        check("wait_ready", 64'(in_ready), 64'd0);
        check("wait_out", 64'(out_valid), 64'd0);
        check("dreq_addr", dreq_addr, addr);
        check("dreq_size", 64'(dreq_size), 64'(size));
        check("dreq_strobe", 64'(dreq_strobe), store ? 64'(model_strobe(addr, int'(size))) : 64'd0);
        check("dreq_wdata", dreq_wdata, store ? (wd << (8 * (addr % 8))) : 64'd0);
        if (kill && k == 0) flush = 1'b1;
        if (k == delay) begin dresp_ok = 1'b1; dresp_rdata = rdata; end
        @(negedge clk);
        flush = 1'b0; dresp_ok = 1'b0; dresp_rdata = {$urandom, $urandom};
      end
      check("dreq_cycles", 64'(hi), 64'(delay + 1));
      check("done_dreq", 64'(dreq_valid), 64'd0);
      check("done_ready", 64'(in_ready), 64'd1);
      check("done_valid", 64'(out_valid), kill ? 64'd0 : 64'd1);
      if (!kill) begin
        check("mem_result", out_result, exp_q.pop_front());
        check("mem_regwrite", 64'(out_regwrite), store ? 64'd0 : 64'(rw));
        check("mem_misalign", 64'(out_misalign), 64'd0);
        check("mem_pc", out_pc, pc);
        check("mem_rd", 64'(out_rd), 64'(rd));
      end
    end
    @(negedge clk);
    check("pulse_end", 64'(out_valid), 64'd0);
  endtask

  task automatic flush_idle();
    check("fi_ready", 64'(in_ready), 64'd1);
    drive_in(2'd1, 2'd0, {$urandom, $urandom}, 64'd0, 1'b0, 1'b1, 64'd0, 5'd1);
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("fi_valid", 64'(out_valid), 64'd0);
    check("fi_dreq", 64'(dreq_valid), 64'd0);
    check("fi_ready2", 64'(in_ready), 64'd1);
  endtask

  task automatic stray_resp();
    dresp_ok = 1'b1;
    @(negedge clk);
    dresp_ok = 1'b0;
    check("stray_valid", 64'(out_valid), 64'd0);
    check("stray_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic reset_mid_wait();
    logic [63:0] a = 64'h3004;
    drive_in(2'd2, 2'd2, a, 64'hCAFE_F00D, 1'b0, 1'b0, 64'h40, 5'd2);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_pre_dreq", 64'(dreq_valid), 64'd1);
    check("rst_pre_strobe", 64'(dreq_strobe), 64'hF0);
    #2 reset = 1'b1;
    #1;
    check("rst_async_dreq", 64'(dreq_valid), 64'd0);
    check("rst_async_strobe", 64'(dreq_strobe), 64'd0);
    check("rst_async_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    stray_resp();
    check("rst_post_dreq", 64'(dreq_valid), 64'd0);
  endtask

  initial begin
    logic [1:0]  memop, size;
    logic [63:0] addr;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; dresp_ok = 1'b0; dresp_rdata = '0;
    in_pc = '0; in_alu_out = '0; in_memop = '0; in_size = '0; in_unsigned = 1'b0;
    in_wdata = '0; in_rd = '0; in_regwrite = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_misc", {out_rd, out_regwrite, out_misalign}, 64'd0);
    check("rst_dreq", {dreq_valid, dreq_strobe}, 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_state", 64'(state_dbg), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(2'd0, 2'd3, 64'h1234, 64'd0, 1'b0, 1'b1, 64'd0, 0, 1'b0);
    run_txn(2'd1, 2'd0, 64'h1003, 64'd0, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 2, 1'b0);
    check("byte_signed_value", out_result, 64'hFFFF_FFFF_FFFF_FF80);
    run_txn(2'd2, 2'd1, 64'h2006, 64'hBEEF, 1'b0, 1'b1, 64'd0, 0, 1'b0);
    run_txn(2'd1, 2'd2, 64'h1002, 64'd0, 1'b0, 1'b1, 64'd0, 0, 1'b0);
    run_txn(2'd1, 2'd3, 64'h1008, 64'd0, 1'b0, 1'b1, {$urandom, $urandom}, 2, 1'b1);
    run_txn(2'd3, 2'd1, 64'h55, 64'd0, 1'b0, 1'b1, 64'd0, 0, 1'b0);
    flush_idle();
    stray_resp();
    reset_mid_wait();

    for (int n = 0; n < 80; n++) begin
      memop = 2'($urandom_range(0, 3));
      size  = 2'($urandom_range(0, 3));
      addr  = {$urandom, $urandom};
      if ($urandom_range(0, 9) < 7) addr = addr & ~((64'd1 << size) - 64'd1);
      run_txn(memop, size, addr, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
              {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) flush_idle();
      if ($urandom_range(0, 7) == 0) stray_resp();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
